dcpu16_xbus: RTL and testbench

- Downstream consumer of the CPU's two memory masters, the instruction/write-back bus (f_*) and the operand bus (g_*).
- Arbitrates both onto one single-ported external memory bus (x_*) using a classic strobe/ack handshake.
- Lets the CPU run against one shared RAM.
- Sits between the CPU top level and the system memory.

---
 rtl/dcpu16_xbus.sv | 112 +++++++++++
 tb/tb_dcpu16_xbus.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcpu16_xbus.sv
// dcpu16_xbus: arbitrates the CPU's f (fetch/write-back) and g (operand) masters onto one
// strobe/ack memory bus. Optional grant timeout is enabled with `define DCPU16_XBUS_TMO_EN.
module dcpu16_xbus #(
  parameter int ARB_RR = 1,
  parameter int TMO_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] f_adr,
  input  logic        f_stb,
  input  logic        f_wre,
  input  logic [15:0] f_dto,
  output logic [15:0] f_dti,
  output logic        f_ack,
  input  logic [15:0] g_adr,
  input  logic        g_stb,
  input  logic        g_wre,
  input  logic [15:0] g_dto,
  output logic [15:0] g_dti,
  output logic        g_ack,
  output logic [15:0] x_adr,
  output logic        x_stb,
  output logic        x_wre,
  output logic [15:0] x_dto,
  input  logic [15:0] x_dti,
  input  logic        x_ack,
  output logic        x_err
);

  typedef enum logic [1:0] {IDLE, FGNT, GGNT} state_t;

  state_t state;
  logic   last_f;    // last completed grant went to f
  logic   grant_f;
  logic   grant_g;
  logic   tmo_hit;
  logic   done;

  // On a tie, f wins unless round-robin is on and f had the previous grant.
  assign grant_f = f_stb & (~g_stb | (ARB_RR == 0) | ~last_f);
  assign grant_g = g_stb & ~grant_f;

`ifdef DCPU16_XBUS_TMO_EN
  logic [TMO_W-1:0] tmo_cnt;

  // A real x_ack in the terminal cycle wins over the forced timeout ack.
  assign tmo_hit = (state != IDLE) & (&tmo_cnt) & ~x_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      x_err   <= 1'b0;
    end else begin
      if (state == IDLE || x_ack) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) x_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign x_err   = 1'b0;
`endif

  assign done  = x_ack | tmo_hit;
  assign f_ack = (state == FGNT) & done;
  assign g_ack = (state == GGNT) & done;
  assign f_dti = tmo_hit ? 16'hFFFF : x_dti;
  assign g_dti = tmo_hit ? 16'hFFFF : x_dti;

  // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_f <= 1'b0;
      x_stb  <= 1'b0;
      x_wre  <= 1'b0;
      x_adr  <= 16'h0000;
      x_dto  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (grant_f) begin
            state <= FGNT;
            x_stb <= 1'b1;
            x_adr <= f_adr;
            x_wre <= f_wre;
            x_dto <= f_dto;
          end else if (grant_g) begin
            state <= GGNT;
            x_stb <= 1'b1;
            x_adr <= g_adr;
            x_wre <= g_wre;
            x_dto <= g_dto;
          end
        end
        FGNT, GGNT: begin
          // x_* hold their latched values until the transfer ends.
          if (done) begin
            state  <= IDLE;
            x_stb  <= 1'b0;
            last_f <= (state == FGNT);
          end
        end
        default: begin
          state <= IDLE;
          x_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcpu16_xbus.sv
// Self-checking bench for dcpu16_xbus: vector table, contention/reset/timeout sequences,
// and randomized two-master traffic checked against a transaction-level model.
module tb_dcpu16_xbus;

  localparam int TB_TMO_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] f_adr, f_dto, g_adr, g_dto;
  logic        f_stb, f_wre, g_stb, g_wre;

  logic [15:0] f_dti, g_dti, x_adr, x_dto, x_dti;
  logic        f_ack, g_ack, x_stb, x_wre, x_ack, x_err;

  logic [15:0] p_f_dti, p_g_dti, p_x_adr, p_x_dto, p_x_dti;
  logic        p_f_ack, p_g_ack, p_x_stb, p_x_wre, p_x_ack, p_x_err;

  int n_vec = 0;
  int n_err = 0;

  dcpu16_xbus #(.ARB_RR(1), .TMO_W(TB_TMO_W)) dut (
    .clk(clk), .rst(rst),
    .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto), .f_dti(f_dti), .f_ack(f_ack),
    .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto), .g_dti(g_dti), .g_ack(g_ack),
    .x_adr(x_adr), .x_stb(x_stb), .x_wre(x_wre), .x_dto(x_dto), .x_dti(x_dti), .x_ack(x_ack),
    .x_err(x_err)
  );

  dcpu16_xbus #(.ARB_RR(0), .TMO_W(TB_TMO_W)) dut_fp (
    .clk(clk), .rst(rst),
    .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto), .f_dti(p_f_dti), .f_ack(p_f_ack),
    .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto), .g_dti(p_g_dti), .g_ack(p_g_ack),
    .x_adr(p_x_adr), .x_stb(p_x_stb), .x_wre(p_x_wre), .x_dto(p_x_dto), .x_dti(p_x_dti),
    .x_ack(p_x_ack), .x_err(p_x_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic        f_stb;
    logic [15:0] f_adr;
    logic        f_wre;
    logic [15:0] f_dto;
    logic        g_stb;
    logic [15:0] g_adr;
    logic        g_wre;
    logic [15:0] g_dto;
    logic        x_ack;
    logic [15:0] x_dti;
    logic        e_stb;
    logic [15:0] e_adr;
    logic        e_wre;
    logic [15:0] e_dto;
    logic        e_fack;
    logic        e_gack;
  } vec_t;

  vec_t vecs [20];

  logic [15:0] dev_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] dev_rd(input logic [15:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    f_stb = 1'b0; g_stb = 1'b0;
    x_ack = 1'b0; p_x_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Randomized traffic: masters hold a request until acked, memory acks after 0..3 cycles.
  task automatic run_random(input int cycles);
    logic prev_stb = 1'b0, prev_ack = 1'b0, pf = 1'b0, pg = 1'b0;
    logic f_act = 1'b0, g_act = 1'b0, exp_stb;
    int   owner = 0, last = 2, lat = 0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      exp_stb = prev_stb ? !prev_ack : (pf | pg);
      check("rnd_x_stb", x_stb, exp_stb);
      if (x_stb && !prev_stb) begin
        if (pf && pg) owner = (last == 1) ? 2 : 1;
        else          owner = pf ? 1 : 2;
        lat = $urandom_range(0, 3);
      end
      if (x_stb) begin
        check("rnd_x_adr", x_adr, (owner == 1) ? f_adr : g_adr);
        check("rnd_x_wre", x_wre, (owner == 1) ? f_wre : g_wre);
        check("rnd_x_dto", x_dto, (owner == 1) ? f_dto : g_dto);
        if (lat == 0) begin
          x_ack = 1'b1;
          x_dti = x_wre ? 16'($urandom) : dev_rd(x_adr);
        end else begin
          x_ack = 1'b0;
          x_dti = 16'($urandom);
          lat--;
        end
      end else begin
        x_ack = 1'($urandom);
        x_dti = 16'($urandom);
      end
      #1;
      check("rnd_f_ack", f_ack, x_stb && x_ack && owner == 1);
      check("rnd_g_ack", g_ack, x_stb && x_ack && owner == 2);
      if (x_stb && x_ack) begin
        if (x_wre) dev_mem[x_adr] = x_dto;
        if (owner == 1) begin
          if (f_wre) ref_mem[f_adr] = f_dto;
          else       check("rnd_f_dti", f_dti, ref_rd(f_adr));
          f_act = 1'b0;
        end else begin
          if (g_wre) ref_mem[g_adr] = g_dto;
          else       check("rnd_g_dti", g_dti, ref_rd(g_adr));
          g_act = 1'b0;
        end
        last = owner;
      end
      prev_stb = x_stb;
      prev_ack = x_stb && x_ack;
      if (!f_act && $urandom_range(0, 1) == 1) begin
        f_act = 1'b1;
        f_adr = 16'($urandom_range(0, 15));
        f_wre = 1'($urandom);
        f_dto = 16'($urandom);
      end
      if (!g_act && $urandom_range(0, 1) == 1) begin
        g_act = 1'b1;
        g_adr = 16'($urandom_range(0, 15));
        g_wre = 1'($urandom);
        g_dto = 16'($urandom);
      end
      f_stb = f_act;
      g_stb = g_act;
      pf = f_stb;
      pg = g_stb;
      tick();
    end
    f_stb = 1'b0;
    g_stb = 1'b0;
    x_ack = 1'b0;
  endtask

  initial begin
    //          f_stb f_adr    wre dto       g_stb g_adr    wre dto       ack dti       e_stb e_adr   e_wre e_dto  fack gack
    vecs[0]  = '{1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h8000, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h8000, 1'b1, 16'h1234, 1'b1, 16'h0000, 1'b1, 16'h8000, 1'b1, 16'h1234, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h8000, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h0042, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 16'h9999, 1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 16'h9999, 1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h5A5A, 1'b1, 16'h0042, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 16'h0001, 1'b1, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 16'h0001, 1'b1, 16'hAAAA, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'hAAAA, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 16'h0001, 1'b1, 16'hAAAA, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'hAAAA, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1, 16'h7777, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1;
    f_stb = 1'b0; f_adr = 16'h0; f_wre = 1'b0; f_dto = 16'h0;
    g_stb = 1'b0; g_adr = 16'h0; g_wre = 1'b0; g_dto = 16'h0;
    x_ack = 1'b0; x_dti = 16'h0; p_x_ack = 1'b0; p_x_dti = 16'h0;
    repeat (2) tick();

    // Reset state, with a request and a stray memory ack present.
    f_stb = 1'b1;
    x_ack = 1'b1;
    tick();
    check("rst_x_stb", x_stb, 1'b0);
    check("rst_x_wre", x_wre, 1'b0);
    check("rst_x_adr", x_adr, 16'h0000);
    check("rst_x_dto", x_dto, 16'h0000);
    check("rst_x_err", x_err, 1'b0);
    check("rst_f_ack", f_ack, 1'b0);
    check("rst_g_ack", g_ack, 1'b0);
    f_stb = 1'b0;
    x_ack = 1'b0;
    rst = 1'b0;

    // Vector table: single read, single write, idle ack, stb drop, waiting master.
    for (int i = 0; i < 20; i++) begin
      f_stb = vecs[i].f_stb; f_adr = vecs[i].f_adr; f_wre = vecs[i].f_wre; f_dto = vecs[i].f_dto;
      g_stb = vecs[i].g_stb; g_adr = vecs[i].g_adr; g_wre = vecs[i].g_wre; g_dto = vecs[i].g_dto;
      x_ack = vecs[i].x_ack; x_dti = vecs[i].x_dti;
      #1;
      check($sformatf("tbl%0d_x_stb", i), x_stb, vecs[i].e_stb);
      if (vecs[i].e_stb) begin
        check($sformatf("tbl%0d_x_adr", i), x_adr, vecs[i].e_adr);
        check($sformatf("tbl%0d_x_wre", i), x_wre, vecs[i].e_wre);
        check($sformatf("tbl%0d_x_dto", i), x_dto, vecs[i].e_dto);
      end
      check($sformatf("tbl%0d_f_ack", i), f_ack, vecs[i].e_fack);
      check($sformatf("tbl%0d_g_ack", i), g_ack, vecs[i].e_gack);
      if (vecs[i].e_fack) check($sformatf("tbl%0d_f_dti", i), f_dti, vecs[i].x_dti);
      if (vecs[i].e_gack) check($sformatf("tbl%0d_g_dti", i), g_dti, vecs[i].x_dti);
      tick();
    end

    // Contention from reset release: round-robin gives f,g,f,g; fixed priority gives f only.
    rst = 1'b1;
    f_stb = 1'b1; f_adr = 16'h0010; f_wre = 1'b0; f_dto = 16'h0;
    g_stb = 1'b1; g_adr = 16'h0020; g_wre = 1'b0; g_dto = 16'h0;
    x_ack = 1'b0; p_x_ack = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      x_ack = x_stb;
      p_x_ack = p_x_stb;
      x_dti = 16'(c);
      p_x_dti = 16'(c);
      #1;
      check($sformatf("rr%0d_x_stb", c), x_stb, (c % 2) == 1);
      check($sformatf("rr%0d_f_ack", c), f_ack, (c % 4) == 1);
      check($sformatf("rr%0d_g_ack", c), g_ack, (c % 4) == 3);
      check($sformatf("fp%0d_f_ack", c), p_f_ack, (c % 2) == 1);
      check($sformatf("fp%0d_g_ack", c), p_g_ack, 1'b0);
      tick();
    end
    f_stb = 1'b0; g_stb = 1'b0; x_ack = 1'b0; p_x_ack = 1'b0;

    // Reset asserted while g owns the bus.
    do_reset();
    g_stb = 1'b1; g_adr = 16'h4444; g_wre = 1'b0;
    tick();
    check("mgr_granted", x_stb, 1'b1);
    rst = 1'b1;
    x_ack = 1'b1;
    #1;
    check("mgr_x_stb", x_stb, 1'b0);
    check("mgr_x_adr", x_adr, 16'h0000);
    check("mgr_g_ack", g_ack, 1'b0);
    g_stb = 1'b0;
    x_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("mgr_idle_stb", x_stb, 1'b0);
    x_ack = 1'b1;
    #1;
    check("mgr_idle_g_ack", g_ack, 1'b0);
    check("mgr_idle_f_ack", f_ack, 1'b0);
    x_ack = 1'b0;
    tick();

`ifdef DCPU16_XBUS_TMO_EN
    // Read that the memory never acknowledges.
    do_reset();
    f_stb = 1'b1; f_adr = 16'h0300; f_wre = 1'b0;
    tick();
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("tmo%0d_x_stb", c), x_stb, 1'b1);
      check($sformatf("tmo%0d_f_ack", c), f_ack, 1'b0);
      tick();
    end
    check("tmo_f_ack", f_ack, 1'b1);
    check("tmo_f_dti", f_dti, 16'hFFFF);
    f_stb = 1'b0;
    tick();
    check("tmo_idle_stb", x_stb, 1'b0);
    check("tmo_x_err", x_err, 1'b1);
    g_stb = 1'b1; g_adr = 16'h0500; g_wre = 1'b0;
    tick();
    check("tmo_g_stb", x_stb, 1'b1);
    x_ack = 1'b1; x_dti = 16'h1111;
    #1;
    check("tmo_g_ack", g_ack, 1'b1);
    check("tmo_g_dti", g_dti, 16'h1111);
    g_stb = 1'b0;
    tick();
    x_ack = 1'b0;
    tick();
    check("tmo_err_sticky", x_err, 1'b1);
`endif

    do_reset();
    run_random(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
